// File: rtl/if_run_ctrl.sv
// Run/step controller and hazard sequencer for the fetch stage; drains the pipe on a halt word.
// Optional cycle counter enabled by defining IF_RUN_CTRL_CYCLE_COUNT_EN (otherwise cycle_count is 0).
module if_run_ctrl #(
  parameter int          CNT_W        = 32,
  parameter int          DRAIN_CYCLES = 4,
  parameter logic [31:0] HALT_WORD    = 32'hFFFF_FFFF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             step,
  input  logic             halt_req,
  input  logic             mem_read_ex,
  input  logic [4:0]       rt_ex,
  input  logic [4:0]       rs_id,
  input  logic [4:0]       rt_id,
  input  logic             branch_taken,
  input  logic             jump,
  input  logic [31:0]      instr_if,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_flush,
  output logic             pipe_enable,
  output logic [2:0]       state,
  output logic             halted,
  output logic [CNT_W-1:0] cycle_count
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RUN    = 3'd1,
    STEP   = 3'd2,
    PAUSE  = 3'd3,
    DRAIN  = 3'd4,
    HALTED = 3'd5
  } runState_t;

  localparam logic [3:0] DRAIN_INIT = 4'(DRAIN_CYCLES);

  runState_t  curState;
  logic [3:0] drainCnt;
  logic       haltedQ;
  logic       active;
  logic       stall;
  logic       flushNow;
  logic       haltDetect;

  assign active     = (curState == RUN) || (curState == STEP);
  assign stall      = mem_read_ex && (rt_ex != 5'd0) && ((rt_ex == rs_id) || (rt_ex == rt_id));
  assign flushNow   = (branch_taken || jump) && !stall;
  // A halt word sitting in a stalled or squashed slot is not a real fetch.
  assign haltDetect = active && (instr_if == HALT_WORD) && !stall && !flushNow;

  always_comb begin
    pc_write    = 1'b0;
    if_id_write = 1'b0;
    if_flush    = 1'b0;
    pipe_enable = 1'b0;
    if (active) begin
      pipe_enable = 1'b1;
      pc_write    = !stall;
      if_id_write = !stall;
      if_flush    = flushNow;
    end else if (curState == DRAIN) begin
      pipe_enable = 1'b1;
      if_id_write = 1'b1;
      if_flush    = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      curState <= IDLE;
      drainCnt <= '0;
      haltedQ  <= 1'b0;
    end else begin
      unique case (curState)
        IDLE: begin
          if (start)     curState <= RUN;
          else if (step) curState <= STEP;
        end
        RUN: begin
          if (halt_req) begin
            curState <= PAUSE;
          end else if (haltDetect) begin
            curState <= DRAIN;
            drainCnt <= DRAIN_INIT;
          end
        end
        STEP: begin
          if (haltDetect) begin
            curState <= DRAIN;
            drainCnt <= DRAIN_INIT;
          end else begin
            curState <= PAUSE;
          end
        end
        PAUSE: begin
          if (start)     curState <= RUN;
          else if (step) curState <= STEP;
        end
        DRAIN: begin
          if (drainCnt <= 4'd1) begin
            curState <= HALTED;
            haltedQ  <= 1'b1;
            drainCnt <= '0;
          end else begin
            drainCnt <= drainCnt - 4'd1;
          end
        end
        HALTED: curState <= HALTED;
        default: curState <= IDLE;
      endcase
    end
  end

  assign state  = curState;
  assign halted = haltedQ;

`ifdef IF_RUN_CTRL_CYCLE_COUNT_EN
  logic [CNT_W-1:0] cycleCnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycleCnt <= '0;
    end else if (active || (curState == DRAIN)) begin
      cycleCnt <= cycleCnt + CNT_W'(1);
    end
  end

  assign cycle_count = cycleCnt;
`else
  assign cycle_count = '0;
`endif

endmodule

// File: tb/tb_if_run_ctrl.sv
// Directed bench for if_run_ctrl: expected outputs are queued per cycle and checked at the falling edge.
module tb_if_run_ctrl;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_RUN    = 3'd1;
  localparam logic [2:0] S_STEP   = 3'd2;
  localparam logic [2:0] S_PAUSE  = 3'd3;
  localparam logic [2:0] S_DRAIN  = 3'd4;
  localparam logic [2:0] S_HALTED = 3'd5;
  localparam logic [31:0] HALTW   = 32'hFFFF_FFFF;

  typedef struct packed {
    logic [2:0]  st;
    logic        pcw;
    logic        ifw;
    logic        fl;
    logic        pen;
    logic        hlt;
    logic [31:0] cnt;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        start;
  logic        step;
  logic        halt_req;
  logic        mem_read_ex;
  logic [4:0]  rt_ex;
  logic [4:0]  rs_id;
  logic [4:0]  rt_id;
  logic        branch_taken;
  logic        jump;
  logic [31:0] instr_if;
  logic        pc_write;
  logic        if_id_write;
  logic        if_flush;
  logic        pipe_enable;
  logic [2:0]  state;
  logic        halted;
  logic [31:0] cycle_count;

  exp_t        expQ[$];
  int          checks;
  int          errors;
  int          expCnt;

  if_run_ctrl #(
    .CNT_W(32),
    .DRAIN_CYCLES(4),
    .HALT_WORD(32'hFFFF_FFFF)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .step(step),
    .halt_req(halt_req),
    .mem_read_ex(mem_read_ex),
    .rt_ex(rt_ex),
    .rs_id(rs_id),
    .rt_id(rt_id),
    .branch_taken(branch_taken),
    .jump(jump),
    .instr_if(instr_if),
    .pc_write(pc_write),
    .if_id_write(if_id_write),
    .if_flush(if_flush),
    .pipe_enable(pipe_enable),
    .state(state),
    .halted(halted),
    .cycle_count(cycle_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] req);
    checks++;
    assert (obs === req) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, req);
    end
  endtask

  task automatic pushExp(input logic [2:0] st, input logic pcw, input logic ifw,
                         input logic fl, input logic pen, input logic hlt);
    exp_t e;
    e.st  = st;
    e.pcw = pcw;
    e.ifw = ifw;
    e.fl  = fl;
    e.pen = pen;
    e.hlt = hlt;
`ifdef IF_RUN_CTRL_CYCLE_COUNT_EN
    e.cnt = 32'(expCnt);
`else
    e.cnt = 32'd0;
`endif
    expQ.push_back(e);
  endtask

  task automatic checkNow(input string tag, output logic pen);
    exp_t e;
    if (expQ.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s: scoreboard empty got 0 expected 1", tag);
      pen = 1'b0;
    end else begin
      e = expQ.pop_front();
      cmp({tag, ".state"},       32'(state),       32'(e.st));
      cmp({tag, ".pc_write"},    32'(pc_write),    32'(e.pcw));
      cmp({tag, ".if_id_write"}, 32'(if_id_write), 32'(e.ifw));
      cmp({tag, ".if_flush"},    32'(if_flush),    32'(e.fl));
      cmp({tag, ".pipe_enable"}, 32'(pipe_enable), 32'(e.pen));
      cmp({tag, ".halted"},      32'(halted),      32'(e.hlt));
      cmp({tag, ".cycle_count"}, cycle_count,      e.cnt);
      pen = e.pen;
    end
  endtask

  // One clock cycle: queue expectation, check at the falling edge, move past the next rising edge.
  task automatic expectCycle(input string tag, input logic [2:0] st, input logic pcw,
                             input logic ifw, input logic fl, input logic pen, input logic hlt);
    logic wasActive;
    pushExp(st, pcw, ifw, fl, pen, hlt);
    @(negedge clk);
    checkNow(tag, wasActive);
    if (wasActive) expCnt++;
    @(posedge clk);
    #1;
    start    = 1'b0;
    step     = 1'b0;
    halt_req = 1'b0;
  endtask

  initial begin
    logic dummy;
    checks = 0;
    errors = 0;
    expCnt = 0;
    reset = 1'b1;
    start = 1'b0;
    step = 1'b0;
    halt_req = 1'b0;
    mem_read_ex = 1'b0;
    rt_ex = 5'd0;
    rs_id = 5'd0;
    rt_id = 5'd0;
    branch_taken = 1'b0;
    jump = 1'b0;
    instr_if = 32'h0000_0013;

    @(posedge clk);
    #1;
    expectCycle("reset", S_IDLE, 0, 0, 0, 0, 0);
    reset = 1'b0;
    expectCycle("idle", S_IDLE, 0, 0, 0, 0, 0);

    start = 1'b1;
    expectCycle("idle_start", S_IDLE, 0, 0, 0, 0, 0);
    expectCycle("run_first", S_RUN, 1, 1, 0, 1, 0);

    mem_read_ex = 1'b1; rt_ex = 5'd5; rs_id = 5'd5; branch_taken = 1'b1;
    expectCycle("stall_wins", S_RUN, 0, 0, 0, 1, 0);
    rt_ex = 5'd0;
    expectCycle("r0_no_stall", S_RUN, 1, 1, 1, 1, 0);
    branch_taken = 1'b0; rs_id = 5'd0; rt_ex = 5'd7; rt_id = 5'd7; jump = 1'b1;
    expectCycle("stall_rt", S_RUN, 0, 0, 0, 1, 0);
    mem_read_ex = 1'b0; rt_ex = 5'd0; rt_id = 5'd0; jump = 1'b0;

    halt_req = 1'b1;
    expectCycle("halt_req", S_RUN, 1, 1, 0, 1, 0);
    expectCycle("pause", S_PAUSE, 0, 0, 0, 0, 0);
    step = 1'b1;
    expectCycle("pause_step", S_PAUSE, 0, 0, 0, 0, 0);
    expectCycle("step_cycle", S_STEP, 1, 1, 0, 1, 0);
    start = 1'b1; step = 1'b1;
    expectCycle("pause_again", S_PAUSE, 0, 0, 0, 0, 0);

    instr_if = HALTW; jump = 1'b1;
    expectCycle("halt_flushed", S_RUN, 1, 1, 1, 1, 0);
    jump = 1'b0; halt_req = 1'b1;
    expectCycle("halt_req_prio", S_RUN, 1, 1, 0, 1, 0);
    start = 1'b1;
    expectCycle("pause_halt_word", S_PAUSE, 0, 0, 0, 0, 0);
    mem_read_ex = 1'b1; rt_ex = 5'd3; rs_id = 5'd3;
    expectCycle("halt_stalled", S_RUN, 0, 0, 0, 1, 0);
    mem_read_ex = 1'b0; rt_ex = 5'd0; rs_id = 5'd0;
    expectCycle("halt_detect", S_RUN, 1, 1, 0, 1, 0);
    instr_if = 32'h0000_0013;
    for (int i = 0; i < 4; i++) expectCycle("drain", S_DRAIN, 0, 1, 1, 1, 0);
    start = 1'b1;
    expectCycle("halted_start", S_HALTED, 0, 0, 0, 0, 1);
    step = 1'b1; halt_req = 1'b1;
    expectCycle("halted_step", S_HALTED, 0, 0, 0, 0, 1);
    expectCycle("halted_stay", S_HALTED, 0, 0, 0, 0, 1);

    reset = 1'b1;
    expCnt = 0;
    expectCycle("reset2", S_IDLE, 0, 0, 0, 0, 0);
    reset = 1'b0;
    start = 1'b1;
    expectCycle("idle_start2", S_IDLE, 0, 0, 0, 0, 0);
    instr_if = HALTW;
    expectCycle("halt_detect2", S_RUN, 1, 1, 0, 1, 0);
    instr_if = 32'h0000_0013;
    expectCycle("drain1", S_DRAIN, 0, 1, 1, 1, 0);

    // Second drain cycle: reset lands between clock edges.
    pushExp(S_DRAIN, 0, 1, 1, 1, 0);
    @(negedge clk);
    checkNow("drain2", dummy);
    reset = 1'b1;
    expCnt = 0;
    #1;
    pushExp(S_IDLE, 0, 0, 0, 0, 0);
    checkNow("async_reset", dummy);
    @(posedge clk);
    #1;
    expectCycle("reset_held", S_IDLE, 0, 0, 0, 0, 0);
    reset = 1'b0;

    step = 1'b1;
    expectCycle("idle_step", S_IDLE, 0, 0, 0, 0, 0);
    mem_read_ex = 1'b1; rt_ex = 5'd2; rt_id = 5'd2;
    expectCycle("step_stall", S_STEP, 0, 0, 0, 1, 0);
    mem_read_ex = 1'b0; rt_ex = 5'd0; rt_id = 5'd0;
    step = 1'b1;
    expectCycle("pause3", S_PAUSE, 0, 0, 0, 0, 0);
    instr_if = HALTW;
    expectCycle("step_halt", S_STEP, 1, 1, 0, 1, 0);
    instr_if = 32'h0000_0013;
    for (int i = 0; i < 4; i++) expectCycle("step_drain", S_DRAIN, 0, 1, 1, 1, 0);
    expectCycle("halted2", S_HALTED, 0, 0, 0, 0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
